// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs mult/multu/div/divu
// with a fixed busy latency, and serves mfhi/mflo/mthi/mtlo.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] MDU_a,
    input  logic [31:0] MDU_b,
    input  logic [3:0]  CU_MDU_op,
    input  logic        E_MDU_start,
    output logic        E_MDU_busy,
    output logic [31:0] E_MDU_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } mdu_op_e;

    logic [31:0]   hi;
    logic [31:0]   lo;
    logic [63:0]   pending;
    logic          pending_commit;
    logic [CW-1:0] cnt;
    logic          busy;

    logic [63:0] result;
    logic        result_commit;
    logic        is_mult;
    logic        is_div;
    logic        start_ok;
    logic        div_zero;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;

    assign is_mult  = (CU_MDU_op == OP_MULT) || (CU_MDU_op == OP_MULTU);
    assign is_div   = (CU_MDU_op == OP_DIV)  || (CU_MDU_op == OP_DIVU);
    assign start_ok = E_MDU_start && !busy && (is_mult || is_div);
    assign div_zero = (MDU_b == 32'd0);

    // The low 64 bits of a product of sign-extended operands equal the signed
    // product. Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly.
    always_comb begin
        result        = 64'd0;
        result_commit = 1'b0;
        prod_s = {{32{MDU_a[31]}}, MDU_a} * {{32{MDU_b[31]}}, MDU_b};
        prod_u = {32'd0, MDU_a} * {32'd0, MDU_b};
        abs_a  = MDU_a[31] ? (32'd0 - MDU_a) : MDU_a;
        abs_b  = MDU_b[31] ? (32'd0 - MDU_b) : MDU_b;
        uq     = abs_a / (div_zero ? 32'd1 : abs_b);
        ur     = abs_a % (div_zero ? 32'd1 : abs_b);
        q_s    = (MDU_a[31] ^ MDU_b[31]) ? (32'd0 - uq) : uq;
        r_s    = MDU_a[31] ? (32'd0 - ur) : ur;
        q_u    = MDU_a / (div_zero ? 32'd1 : MDU_b);
        r_u    = MDU_a % (div_zero ? 32'd1 : MDU_b);
        case (CU_MDU_op)
            OP_MULT: begin
                result        = prod_s;
                result_commit = 1'b1;
            end
            OP_MULTU: begin
                result        = prod_u;
                result_commit = 1'b1;
            end
            OP_DIV: begin
                result        = {r_s, q_s};
                result_commit = !div_zero;
            end
            OP_DIVU: begin
                result        = {r_u, q_u};
                result_commit = !div_zero;
            end
            default: ;
        endcase
    end

    // A divide by zero still occupies the unit but leaves HI/LO untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi             <= 32'd0;
            lo             <= 32'd0;
            pending        <= 64'd0;
            pending_commit <= 1'b0;
            cnt            <= '0;
            busy           <= 1'b0;
        end else if (busy) begin
            if (cnt == CW'(1)) begin
                if (pending_commit) begin
                    hi <= pending[63:32];
                    lo <= pending[31:0];
                end
                cnt  <= '0;
                busy <= 1'b0;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end else if (start_ok) begin
            pending        <= result;
            pending_commit <= result_commit;
            cnt            <= is_mult ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            busy           <= 1'b1;
        end else if (!E_MDU_start) begin
            if (CU_MDU_op == OP_MTHI) hi <= MDU_a;
            if (CU_MDU_op == OP_MTLO) lo <= MDU_a;
        end
    end

    always_comb begin
        case (CU_MDU_op)
            OP_MFHI: E_MDU_out = hi;
            OP_MFLO: E_MDU_out = lo;
            default: E_MDU_out = 32'd0;
        endcase
    end

    assign E_MDU_busy = busy;

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: directed vectors queue expected mfhi/mflo
// values and busy-run lengths; a negedge monitor pops and compares them.
module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic [31:0] MDU_a;
    logic [31:0] MDU_b;
    logic [3:0]  CU_MDU_op;
    logic        E_MDU_start;
    logic        E_MDU_busy;
    logic [31:0] E_MDU_out;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } rd_t;

    rd_t rd_q[$];
    int  busy_q[$];
    int  checks = 0;
    int  errors = 0;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .MDU_a      (MDU_a),
        .MDU_b      (MDU_b),
        .CU_MDU_op  (CU_MDU_op),
        .E_MDU_start(E_MDU_start),
        .E_MDU_busy (E_MDU_busy),
        .E_MDU_out  (E_MDU_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic start);
        @(posedge clk);
        #1;
        CU_MDU_op   = op;
        MDU_a       = a;
        MDU_b       = b;
        E_MDU_start = start;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(4'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic read_reg(input string name, input logic [3:0] op, input logic [31:0] exp);
        rd_q.push_back('{name: name, exp: exp});
        apply_stimulus(op, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic start_op(input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int busy_len);
        busy_q.push_back(busy_len);
        apply_stimulus(op, a, b, 1'b1);
    endtask

    // Monitor: each mfhi/mflo cycle consumes one expected read; each busy
    // run is measured in cycles and compared when busy falls.
    initial begin
        int run;
        rd_t item;
        run = 0;
        forever begin
            @(negedge clk);
            if (CU_MDU_op == 4'd5 || CU_MDU_op == 4'd6) begin
                if (rd_q.size() == 0) begin
                    check_output("unexpected_read", E_MDU_out, 32'hxxxxxxxx);
                end else begin
                    item = rd_q.pop_front();
                    check_output(item.name, E_MDU_out, item.exp);
                end
            end
            if (E_MDU_busy) begin
                run++;
            end else if (run != 0) begin
                if (busy_q.size() == 0) check_output("unexpected_busy", 32'(run), 32'd0);
                else check_output("busy_len", 32'(run), 32'(busy_q.pop_front()));
                run = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        reset       = 1'b1;
        MDU_a       = 32'd0;
        MDU_b       = 32'd0;
        CU_MDU_op   = 4'd0;
        E_MDU_start = 1'b0;
        idle(2);
        reset = 1'b0;
        check_output("reset_busy", {31'd0, E_MDU_busy}, 32'd0);
        read_reg("reset_hi", 4'd5, 32'd0);
        read_reg("reset_lo", 4'd6, 32'd0);

        // Signed mult: -1 * 2
        start_op(4'd1, 32'hFFFFFFFF, 32'h00000002, 5);
        idle(5);
        read_reg("mult_hi", 4'd5, 32'hFFFFFFFF);
        read_reg("mult_lo", 4'd6, 32'hFFFFFFFE);

        // Unsigned mult, with reads of the old HI/LO while busy
        start_op(4'd2, 32'hFFFFFFFF, 32'h00000002, 5);
        read_reg("multu_busy_lo", 4'd6, 32'hFFFFFFFE);
        read_reg("multu_busy_hi", 4'd5, 32'hFFFFFFFF);
        idle(3);
        read_reg("multu_hi", 4'd5, 32'h00000001);
        read_reg("multu_lo", 4'd6, 32'hFFFFFFFE);

        // Signed div: -7 / 2
        start_op(4'd3, 32'hFFFFFFF9, 32'h00000002, 10);
        idle(10);
        read_reg("div_lo", 4'd6, 32'hFFFFFFFD);
        read_reg("div_hi", 4'd5, 32'hFFFFFFFF);

        // Signed overflow case
        start_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 10);
        idle(10);
        read_reg("divovf_lo", 4'd6, 32'h80000000);
        read_reg("divovf_hi", 4'd5, 32'h00000000);

        // Divide by zero keeps moved-in HI/LO
        apply_stimulus(4'd7, 32'h00001234, 32'd0, 1'b0);
        apply_stimulus(4'd8, 32'h00005678, 32'd0, 1'b0);
        start_op(4'd4, 32'd7, 32'd0, 10);
        idle(10);
        read_reg("divz_hi", 4'd5, 32'h00001234);
        read_reg("divz_lo", 4'd6, 32'h00005678);

        // mthi visible on the next cycle
        apply_stimulus(4'd7, 32'hDEADBEEF, 32'd0, 1'b0);
        read_reg("mthi_hi", 4'd5, 32'hDEADBEEF);

        // mtlo and a second start during busy are both ignored
        start_op(4'd1, 32'd5, 32'd7, 5);
        apply_stimulus(4'd8, 32'hAAAAAAAA, 32'd0, 1'b0);
        apply_stimulus(4'd1, 32'd100, 32'd100, 1'b1);
        read_reg("mtlo_busy_lo", 4'd6, 32'h00005678);
        idle(2);
        read_reg("restart_lo", 4'd6, 32'd35);
        read_reg("restart_hi", 4'd5, 32'd0);

        // Reset during the second busy cycle aborts the mult
        start_op(4'd1, 32'd3, 32'd4, 2);
        idle(1);
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_output("rst_async_busy", {31'd0, E_MDU_busy}, 32'd0);
        CU_MDU_op = 4'd6;
        #1;
        check_output("rst_async_lo", E_MDU_out, 32'd0);
        CU_MDU_op = 4'd5;
        #1;
        check_output("rst_async_hi", E_MDU_out, 32'd0);
        CU_MDU_op = 4'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(6);
        read_reg("rst_late_lo", 4'd6, 32'd0);
        read_reg("rst_late_hi", 4'd5, 32'd0);

        idle(3);
        check_output("rd_q_empty", 32'(rd_q.size()), 32'd0);
        check_output("busy_q_empty", 32'(busy_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
